inst_mem_pipe: RTL

- Parametrised, pipelined instruction memory. Successor to the combinational instruction ROM.
- Sits between the fetch stage and instruction storage. Adds configurable word width, depth and read latency.
- Adds a valid/ready request/response handshake with back-pressure, plus address fault detection.
- Optional program-load write port for boot/debug.

---
 rtl/inst_mem_pipe_if.sv | 30 +++
 rtl/inst_mem_pipe.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/inst_mem_pipe_if.sv
// inst_mem_pipe_if: fetch request / response bundle between the fetch stage
// (master) and the pipelined instruction memory (slave).
//
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both high. A response transfers on a rising edge where
// rsp_valid and rsp_ready are both high. req_valid does not depend on
// req_ready. While rsp_valid is high and rsp_ready is low, rsp_inst and
// rsp_err hold stable.
interface inst_mem_pipe_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_inst;
  logic [1:0]        rsp_err;

  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_inst, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_inst, rsp_err
  );
endinterface

// File: rtl/inst_mem_pipe.sv
// inst_mem_pipe: pipelined instruction memory with valid/ready fetch port,
// READ_LAT (1 or 2) cycle read latency, a 2-entry in-order response buffer
// and address fault reporting (01 misaligned, 10 out of range).
//
// Optional feature macro: INST_MEM_LOAD_EN adds the ld_en/ld_addr/ld_data
// program-load write port. Without it the memory is a read-only image
// produced by image_word().
//
// Credit scheme: requests in the read pipeline plus entries in the response
// buffer never exceed 2, so every accepted request has a buffer slot
// reserved and back-pressure never drops data.
module inst_mem_pipe #(
  parameter int          DATA_W   = 32,
  parameter int          ADDR_W   = 32,
  parameter int          DEPTH    = 4096,
  parameter int          READ_LAT = 1,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic                     clk,
  input  logic                     rst,
`ifdef INST_MEM_LOAD_EN
  input  logic                     ld_en,
  input  logic [$clog2(DEPTH)-1:0] ld_addr,
  input  logic [DATA_W-1:0]        ld_data,
`endif
  inst_mem_pipe_if.slave           bus
);
  localparam int              OFF_W   = $clog2(DATA_W / 8);
  localparam int              IDX_W   = $clog2(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_L = DEPTH;

  // Reject illegal configurations while elaborating.
  if (DATA_W != 32 && DATA_W != 64) begin : g_bad_data_w
    $error("inst_mem_pipe: DATA_W must be 32 or 64");
  end
  if (READ_LAT != 1 && READ_LAT != 2) begin : g_bad_read_lat
    $error("inst_mem_pipe: READ_LAT must be 1 or 2");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("inst_mem_pipe: DEPTH must be a power of two >= 2");
  end

  logic [ADDR_W-1:0] word_idx;
  logic              mis_fault;
  logic              oor_fault;
  logic [DATA_W-1:0] mem_word;
  logic [DATA_W-1:0] fetch_inst;
  logic [1:0]        fetch_err;
  logic              load_busy;

  logic              accept;
  logic              pop;
  logic              inflight;
  logic              push;
  logic [DATA_W-1:0] push_inst;
  logic [1:0]        push_err;

  logic [1:0]        q_cnt;
  logic [1:0]        used;
  logic              rd_ptr;
  logic              wr_ptr;
  logic              rsp_v;
  logic [DATA_W-1:0] q_inst [2];
  logic [1:0]        q_err  [2];

  assign word_idx  = bus.req_addr >> OFF_W;
  assign mis_fault = |bus.req_addr[OFF_W-1:0];
  assign oor_fault = ({1'b0, word_idx} >= DEPTH_L);

`ifdef INST_MEM_LOAD_EN
  logic [DATA_W-1:0] mem [DEPTH];

  // Program-load write; contents survive reset.
  always_ff @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
  end

  assign mem_word  = mem[word_idx[IDX_W-1:0]];
  assign load_busy = ld_en;
`else
  // Boot image of the read-only memory, one word per index.
  function automatic logic [DATA_W-1:0] image_word(input logic [IDX_W-1:0] idx);
    logic [31:0] i32;
    logic [63:0] w;
    i32 = 32'(idx);
    w   = {~i32 ^ 32'h5A5A_5A5A, (i32 * 32'h9E37_79B1) ^ 32'hC0DE_0000};
    return w[DATA_W-1:0];
  endfunction

  assign mem_word  = image_word(word_idx[IDX_W-1:0]);
  assign load_busy = 1'b0;
`endif

  // Classify the presented address; faulted fetches return the NOP word,
  // misalignment taking priority over range.
  always_comb begin
    fetch_err  = 2'b00;
    fetch_inst = mem_word;
    if (mis_fault) begin
      fetch_err  = 2'b01;
      fetch_inst = DATA_W'(NOP_WORD);
    end else if (oor_fault) begin
      fetch_err  = 2'b10;
      fetch_inst = DATA_W'(NOP_WORD);
    end
  end

  // A pop in this cycle returns its credit immediately.
  assign rsp_v         = (q_cnt != 2'd0);
  assign pop           = rsp_v && bus.rsp_ready;
  assign used          = q_cnt + {1'b0, inflight} - {1'b0, pop};
  assign bus.req_ready = !load_busy && (used < 2'd2);
  assign accept        = bus.req_valid && bus.req_ready;

  if (READ_LAT == 2) begin : g_lat2
    logic              st_v;
    logic [DATA_W-1:0] st_inst;
    logic [1:0]        st_err;

    // Extra read stage between acceptance and the response buffer.
    always_ff @(posedge clk) begin
      if (rst) st_v <= 1'b0;
      else     st_v <= accept;
      if (accept) begin
        st_inst <= fetch_inst;
        st_err  <= fetch_err;
      end
    end

    assign push      = st_v;
    assign push_inst = st_inst;
    assign push_err  = st_err;
    assign inflight  = st_v;
  end else begin : g_lat1
    assign push      = accept;
    assign push_inst = fetch_inst;
    assign push_err  = fetch_err;
    assign inflight  = 1'b0;
  end

  // Response buffer pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_cnt  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      q_cnt <= q_cnt + {1'b0, push} - {1'b0, pop};
    end
  end

  // Response buffer storage; no reset needed, occupancy qualifies it.
  always_ff @(posedge clk) begin
    if (push) begin
      q_inst[wr_ptr] <= push_inst;
      q_err[wr_ptr]  <= push_err;
    end
  end

  assign bus.rsp_valid = rsp_v;
  assign bus.rsp_inst  = rsp_v ? q_inst[rd_ptr] : '0;
  assign bus.rsp_err   = rsp_v ? q_err[rd_ptr]  : 2'b00;
endmodule
